q_frag_readback: RTL and testbench

- Readback side of the PP3 logic-cell flip-flops: snapshots a bank of Q_FRAG QZ outputs on request.
- Streams the snapshot out serially, LSB first, under a valid/ready handshake, followed by one even-parity beat.
- Sits between the fabric FF outputs and the debug/config readback path. It lets test and debug logic observe register state without disturbing the flip-flops.

---
 rtl/q_frag_readback.sv | 112 +++++++++++
 tb/tb_q_frag_readback.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/q_frag_readback.sv
// q_frag_readback: snapshots a bank of Q_FRAG QZ outputs on request and
// streams the captured bits out LSB first under valid/ready, followed by
// one even-parity beat. The observed flip-flops are never disturbed.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no snapshot held; waiting for CAP_REQ
// SHIFT | presenting data beats, one captured bit per accepted beat
// PAR   | presenting the even-parity beat (RB_LAST high)

module q_frag_readback #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 6
) (
    input  logic             QCK,
    input  logic             QRTN,
    input  logic             CAP_REQ,
    input  logic [WIDTH-1:0] QZ_BUS,
    input  logic             RB_RDY,
    input  logic             OVR_CLR,
    output logic             RB_VLD,
    output logic             RB_DO,
    output logic             RB_LAST,
    output logic             BUSY,
    output logic             CAP_ACK,
    output logic             OVR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic [CNT_W-1:0] count;
    logic             parity;

    // Sequencer: capture, shift-out and parity beat, with every visible
    // output registered alongside the state so nothing is decoded from inputs.
    always_ff @(posedge QCK or negedge QRTN) begin
        if (!QRTN) begin
            state   <= IDLE;
            shadow  <= '0;
            count   <= '0;
            parity  <= 1'b0;
            RB_VLD  <= 1'b0;
            RB_DO   <= 1'b0;
            RB_LAST <= 1'b0;
            BUSY    <= 1'b0;
            CAP_ACK <= 1'b0;
        end else begin
            CAP_ACK <= 1'b0;
            case (state)
                IDLE: begin
                    if (CAP_REQ) begin
                        shadow  <= QZ_BUS;
                        parity  <= ^QZ_BUS;
                        count   <= '0;
                        CAP_ACK <= 1'b1;
                        BUSY    <= 1'b1;
                        RB_VLD  <= 1'b1;
                        RB_DO   <= QZ_BUS[0];
                        RB_LAST <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (RB_RDY) begin
                        shadow <= shadow >> 1;
                        count  <= count + CNT_W'(1);
                        if (count == LAST_BIT) begin
                            RB_DO   <= parity;
                            RB_LAST <= 1'b1;
                            state   <= PAR;
                        end else begin
                            RB_DO <= shadow[1];
                        end
                    end
                end
                PAR: begin
                    if (RB_RDY) begin
                        BUSY    <= 1'b0;
                        RB_VLD  <= 1'b0;
                        RB_DO   <= 1'b0;
                        RB_LAST <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky overrun: a request arriving outside IDLE is dropped and flagged;
    // set takes priority over a clear on the same edge.
    always_ff @(posedge QCK or negedge QRTN) begin
        if (!QRTN) begin
            OVR <= 1'b0;
        end else if (CAP_REQ && (state != IDLE)) begin
            OVR <= 1'b1;
        end else if (OVR_CLR) begin
            OVR <= 1'b0;
        end
    end

endmodule

// File: tb/tb_q_frag_readback.sv
// Directed bench for q_frag_readback with a beat scoreboard: expected beats
// are queued when a capture is driven and popped on each accepted beat.

module tb_q_frag_readback;

    localparam int WIDTH = 16;
    localparam int CNT_W = 6;

    logic             QCK = 1'b0;
    logic             QRTN = 1'b0;
    logic             CAP_REQ = 1'b0;
    logic [WIDTH-1:0] QZ_BUS = '0;
    logic             RB_RDY = 1'b1;
    logic             OVR_CLR = 1'b0;
    logic             RB_VLD, RB_DO, RB_LAST, BUSY, CAP_ACK, OVR;

    q_frag_readback #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .QCK     (QCK),
        .QRTN    (QRTN),
        .CAP_REQ (CAP_REQ),
        .QZ_BUS  (QZ_BUS),
        .RB_RDY  (RB_RDY),
        .OVR_CLR (OVR_CLR),
        .RB_VLD  (RB_VLD),
        .RB_DO   (RB_DO),
        .RB_LAST (RB_LAST),
        .BUSY    (BUSY),
        .CAP_ACK (CAP_ACK),
        .OVR     (OVR)
    );

    always #5 QCK = ~QCK;

    typedef struct packed {
        logic dbit;
        logic last;
    } beat_t;

    beat_t exp_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    logic  hold_pend = 1'b0;
    logic  hold_val  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the beats a capture of d must produce: LSB first, then even parity.
    task automatic push_snapshot(input logic [WIDTH-1:0] d);
        logic p;
        p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            exp_q.push_back('{dbit: d[i], last: 1'b0});
            p = p ^ d[i];
        end
        exp_q.push_back('{dbit: p, last: 1'b1});
    endtask

    // One clock: score any beat handshaken on this edge, then step to #1 after it.
    task automatic tick();
        beat_t b;
        if (RB_VLD === 1'b1 && RB_RDY === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 64'(RB_DO), 64'hDEAD);
            end else begin
                b = exp_q.pop_front();
                chk("beat_data", 64'(RB_DO), 64'(b.dbit));
                chk("beat_last", 64'(RB_LAST), 64'(b.last));
            end
        end
        if (RB_VLD === 1'b1 && RB_RDY === 1'b0) begin
            hold_pend = 1'b1;
            hold_val  = RB_DO;
        end
        @(posedge QCK);
        #1;
        if (hold_pend) begin
            chk("hold_vld", 64'(RB_VLD), 64'h1);
            chk("hold_do", 64'(RB_DO), 64'(hold_val));
            hold_pend = 1'b0;
        end
    endtask

    task automatic capture(input logic [WIDTH-1:0] d);
        CAP_REQ = 1'b1;
        QZ_BUS  = d;
        push_snapshot(d);
        tick();
        CAP_REQ = 1'b0;
        chk("cap_ack", 64'(CAP_ACK), 64'h1);
        chk("cap_busy", 64'(BUSY), 64'h1);
    endtask

    // Run until the stream ends; toggle selects the 1,0,0,1 ready pattern.
    task automatic drain(input bit toggle, output int busy_cycles, output int acks);
        int n;
        n    = 0;
        acks = 0;
        while (BUSY === 1'b1 && n < 200) begin
            RB_RDY = toggle ? ((n % 4) == 0 || (n % 4) == 3) : 1'b1;
            n++;
            tick();
            if (CAP_ACK === 1'b1) acks++;
        end
        RB_RDY = 1'b1;
        busy_cycles = n;
        chk("drain_idle", 64'(BUSY), 64'h0);
        chk("drain_queue_empty", 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        int cyc, acks;

        // Reset state
        #12;
        chk("rst_vld", 64'(RB_VLD), 64'h0);
        chk("rst_do", 64'(RB_DO), 64'h0);
        chk("rst_last", 64'(RB_LAST), 64'h0);
        chk("rst_busy", 64'(BUSY), 64'h0);
        chk("rst_ack", 64'(CAP_ACK), 64'h0);
        chk("rst_ovr", 64'(OVR), 64'h0);
        QRTN = 1'b1;
        tick();

        // 0xA5C3 with ready high: 17 busy cycles, single ack
        capture(16'hA5C3);
        drain(1'b0, cyc, acks);
        chk("a5c3_busy_cycles", 64'(cyc), 64'd17);
        chk("a5c3_extra_acks", 64'(acks), 64'd0);

        // 0x0001 with ready toggling 1,0,0,1
        capture(16'h0001);
        drain(1'b1, cyc, acks);
        chk("tog_extra_acks", 64'(acks), 64'd0);

        // Overrun during beat 5, then clear, then set-vs-clear collision
        capture(16'h3C5A);
        for (int i = 0; i < 5; i++) tick();
        CAP_REQ = 1'b1;
        tick();
        CAP_REQ = 1'b0;
        chk("ovr_set", 64'(OVR), 64'h1);
        chk("ovr_no_ack", 64'(CAP_ACK), 64'h0);
        drain(1'b0, cyc, acks);
        chk("ovr_no_second_ack", 64'(acks), 64'd0);
        chk("ovr_sticky", 64'(OVR), 64'h1);
        OVR_CLR = 1'b1;
        tick();
        OVR_CLR = 1'b0;
        chk("ovr_clr", 64'(OVR), 64'h0);
        capture(16'h00F0);
        tick();
        CAP_REQ = 1'b1;
        OVR_CLR = 1'b1;
        tick();
        CAP_REQ = 1'b0;
        OVR_CLR = 1'b0;
        chk("ovr_set_wins", 64'(OVR), 64'h1);
        drain(1'b0, cyc, acks);
        OVR_CLR = 1'b1;
        tick();
        OVR_CLR = 1'b0;
        chk("ovr_clr2", 64'(OVR), 64'h0);

        // QZ_BUS changes after capture do not leak into the stream
        capture(16'h0000);
        QZ_BUS = 16'hFFFF;
        drain(1'b0, cyc, acks);

        // Asynchronous reset during beat 9
        capture(16'h5A5A);
        for (int i = 0; i < 9; i++) tick();
        #2 QRTN = 1'b0;
        #1;
        chk("arst_vld", 64'(RB_VLD), 64'h0);
        chk("arst_do", 64'(RB_DO), 64'h0);
        chk("arst_last", 64'(RB_LAST), 64'h0);
        chk("arst_busy", 64'(BUSY), 64'h0);
        exp_q.delete();
        tick();
        QRTN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_idle", 64'(RB_VLD), 64'h0);
        end
        capture(16'h1234);
        drain(1'b0, cyc, acks);
        chk("post_rst_busy_cycles", 64'(cyc), 64'd17);

        // CAP_REQ held high: captures only at cycles 0 and 18
        acks = 0;
        CAP_REQ = 1'b1;
        for (int i = 0; i < 36; i++) begin
            QZ_BUS = (i < 18) ? 16'h8001 : 16'h7FFE;
            if (i == 0 || i == 18) push_snapshot(QZ_BUS);
            tick();
            chk("held_ack", 64'(CAP_ACK), 64'((i == 0 || i == 18) ? 1 : 0));
            if (CAP_ACK === 1'b1) acks++;
            if (i == 1) chk("held_ovr", 64'(OVR), 64'h1);
        end
        CAP_REQ = 1'b0;
        chk("held_two_captures", 64'(acks), 64'd2);
        drain(1'b0, cyc, acks);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
